// File: rtl/prio_pkg.sv
// Shared types and helpers for the rotating priority resolver.
//   state_e     : acknowledge handshake state (IDLE, WAIT2)
//   NUM_IRQ_MAX : largest supported channel count
//   rank()      : priority rank of a channel, 0 = highest
package prio_pkg;

  localparam int NUM_IRQ_MAX = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } state_e;

  // rank = (id - lowest - 1) mod n, for id and lowest in [0, n-1].
  // Computed with one conditional subtract so no divider is inferred.
  function automatic int rank(input int id, input int lowest, input int n);
    int d;
    d = id + n - 1 - lowest;
    if (d >= n) d = d - n;
    return d;
  endfunction

endpackage

// File: rtl/rot_prio_enc.sv
// Rotating priority encoder (combinational).
//   vec         : candidate channels
//   lowest_prio : channel currently holding the lowest priority
//   found       : any bit of vec set
//   id          : set channel with the lowest rank (valid when found)
module rot_prio_enc
  import prio_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [ID_W-1:0]    lowest_prio,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  int best;

  always_comb begin
    best  = NUM_IRQ;
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i] && (rank(i, int'(lowest_prio), NUM_IRQ) < best)) begin
        best  = rank(i, int'(lowest_prio), NUM_IRQ);
        found = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_resolver_rot.sv
// Interrupt priority resolver with in-service tracking and rotation.
//   clk, rst_n            : clock, async active-low reset
//   irr, imr              : requests and mask (1 = masked)
//   aeoi_en, rot_aeoi     : automatic EOI at inta_2, optionally rotating
//   inta_1, inta_2        : two-pulse acknowledge sequence
//   eoi_*                 : EOI command (specific / non-specific, rotate)
//   setp_*                : set-priority command (channel becomes lowest)
//   int_req               : registered request to CPU
//   irr_clr               : one-hot IRR clear pulse at inta_1
//   ack_valid/ack_id/spurious : acknowledge result pulse at inta_2
//   isr, lowest_prio      : in-service register and rotation pointer
module prio_resolver_rot
  import prio_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               aeoi_en,
  input  logic               rot_aeoi,
  input  logic               inta_1,
  input  logic               inta_2,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [ID_W-1:0]    eoi_level,
  input  logic               setp_valid,
  input  logic [ID_W-1:0]    setp_level,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] irr_clr,
  output logic               ack_valid,
  output logic [ID_W-1:0]    ack_id,
  output logic               spurious,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    lowest_prio
);

  localparam logic [NUM_IRQ-1:0] ONE     = NUM_IRQ'(1);
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_IRQ - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;          // channel latched at inta_1
  logic                 spur_q, spur_d;      // inta_1 found no winner
  logic [NUM_IRQ-1:0]   isr_q, isr_d;
  logic [ID_W-1:0]      lowest_q, lowest_d;
  logic                 int_req_q, int_req_d;
  logic [NUM_IRQ-1:0]   irr_clr_q, irr_clr_d;
  logic                 ack_valid_q, ack_valid_d;
  logic [ID_W-1:0]      ack_id_q, ack_id_d;
  logic                 spurious_q, spurious_d;

  logic [NUM_IRQ-1:0]   pend;
  logic                 p_found, i_found;
  logic [ID_W-1:0]      p_id, i_id;
  logic [NUM_IRQ-1:0]   ack_set, aeoi_clr, eoi_clr;

  assign pend = irr & ~imr;

  rot_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_pend_enc (
    .vec(pend), .lowest_prio(lowest_q), .found(p_found), .id(p_id)
  );

  rot_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_enc (
    .vec(isr_q), .lowest_prio(lowest_q), .found(i_found), .id(i_id)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    spur_d      = spur_q;
    lowest_d    = lowest_q;
    irr_clr_d   = '0;
    ack_valid_d = 1'b0;
    ack_id_d    = ack_id_q;
    spurious_d  = 1'b0;
    ack_set     = '0;
    aeoi_clr    = '0;
    eoi_clr     = '0;

    // Rotation sources are applied lowest-precedence first so later
    // assignments win: set-priority < AEOI rotate < EOI rotate.
    if (setp_valid && (int'(setp_level) < NUM_IRQ)) lowest_d = setp_level;

    case (state_q)
      IDLE: begin
        if (inta_1) begin
          state_d = WAIT2;
          if (p_found) begin
            id_d      = p_id;
            spur_d    = 1'b0;
            ack_set   = ONE << p_id;
            irr_clr_d = ONE << p_id;
          end else begin
            id_d   = LAST_ID;
            spur_d = 1'b1;
          end
        end
      end
      WAIT2: begin
        if (inta_2) begin
          state_d     = IDLE;
          ack_valid_d = 1'b1;
          ack_id_d    = id_q;
          spurious_d  = spur_q;
          if (aeoi_en && !spur_q) begin
            aeoi_clr = ONE << id_q;
            if (rot_aeoi) lowest_d = id_q;
          end
        end
      end
    endcase

    if (eoi_valid) begin
      if (!eoi_specific) begin
        // Non-specific EOI with nothing in service is a no-op.
        if (i_found) begin
          eoi_clr = ONE << i_id;
          if (eoi_rotate) lowest_d = i_id;
        end
      end else if (int'(eoi_level) < NUM_IRQ) begin
        eoi_clr = ONE << eoi_level;
        if (eoi_rotate) lowest_d = eoi_level;
      end
    end

    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;

    // Request is suppressed for the whole acknowledge handshake; the
    // comparison uses pre-edge pend/isr, giving one cycle of latency.
    int_req_d = (state_d == IDLE) && p_found &&
                (!i_found || (rank(int'(p_id), int'(lowest_q), NUM_IRQ) <
                              rank(int'(i_id), int'(lowest_q), NUM_IRQ)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= '0;
      spur_q      <= 1'b0;
      isr_q       <= '0;
      lowest_q    <= LAST_ID;
      int_req_q   <= 1'b0;
      irr_clr_q   <= '0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      spur_q      <= spur_d;
      isr_q       <= isr_d;
      lowest_q    <= lowest_d;
      int_req_q   <= int_req_d;
      irr_clr_q   <= irr_clr_d;
      ack_valid_q <= ack_valid_d;
      ack_id_q    <= ack_id_d;
      spurious_q  <= spurious_d;
    end
  end

  assign int_req     = int_req_q;
  assign irr_clr     = irr_clr_q;
  assign ack_valid   = ack_valid_q;
  assign ack_id      = ack_id_q;
  assign spurious    = spurious_q;
  assign isr         = isr_q;
  assign lowest_prio = lowest_q;

endmodule

// File: tb/tb_prio_resolver_rot.sv
module tb_prio_resolver_rot;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irr, imr;
  logic         aeoi_en, rot_aeoi, inta_1, inta_2;
  logic         eoi_valid, eoi_specific, eoi_rotate, setp_valid;
  logic [W-1:0] eoi_level, setp_level;
  logic         int_req, ack_valid, spurious;
  logic [N-1:0] irr_clr, isr;
  logic [W-1:0] ack_id, lowest_prio;

  always #5 clk = ~clk;

  prio_resolver_rot #(.NUM_IRQ(N), .ID_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr),
    .aeoi_en(aeoi_en), .rot_aeoi(rot_aeoi), .inta_1(inta_1), .inta_2(inta_2),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate),
    .eoi_level(eoi_level), .setp_valid(setp_valid), .setp_level(setp_level),
    .int_req(int_req), .irr_clr(irr_clr), .ack_valid(ack_valid), .ack_id(ack_id),
    .spurious(spurious), .isr(isr), .lowest_prio(lowest_prio)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: channel state as plain bit vectors and integers.
  bit [N-1:0] m_isr, m_irr_clr;
  int         m_lowest, m_id, m_ack_id;
  bit         m_wait, m_spur, m_int_req, m_ack_valid, m_spurious;

  function automatic int mrank(int i, int low);
    return (i - low - 1 + 2 * N) % N;
  endfunction

  task automatic model_reset();
    m_isr = '0; m_irr_clr = '0; m_lowest = N - 1; m_id = 0; m_ack_id = 0;
    m_wait = 0; m_spur = 0; m_int_req = 0; m_ack_valid = 0; m_spurious = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit [N-1:0] pend, clr, setb;
    int win, top, eoi_rot, aeoi_rot, nlow;
    pend = irr & ~imr;
    win = -1; top = -1;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && (win < 0 || mrank(i, m_lowest) < mrank(win, m_lowest))) win = i;
      if (m_isr[i] && (top < 0 || mrank(i, m_lowest) < mrank(top, m_lowest))) top = i;
    end
    clr = '0; setb = '0; eoi_rot = -1; aeoi_rot = -1; nlow = m_lowest;
    m_irr_clr = '0; m_ack_valid = 0; m_spurious = 0;
    if (!m_wait) begin
      if (inta_1) begin
        m_wait = 1;
        if (win >= 0) begin
          m_id = win; m_spur = 0; setb[win] = 1'b1; m_irr_clr[win] = 1'b1;
        end else begin
          m_id = N - 1; m_spur = 1;
        end
      end
    end else if (inta_2) begin
      m_wait = 0; m_ack_valid = 1; m_ack_id = m_id; m_spurious = m_spur;
      if (aeoi_en && !m_spur) begin
        clr[m_id] = 1'b1;
        if (rot_aeoi) aeoi_rot = m_id;
      end
    end
    if (eoi_valid) begin
      if (!eoi_specific) begin
        if (top >= 0) begin
          clr[top] = 1'b1;
          if (eoi_rotate) eoi_rot = top;
        end
      end else begin
        clr[eoi_level] = 1'b1;
        if (eoi_rotate) eoi_rot = int'(eoi_level);
      end
    end
    if (setp_valid) nlow = int'(setp_level);
    if (aeoi_rot >= 0) nlow = aeoi_rot;
    if (eoi_rot >= 0) nlow = eoi_rot;
    m_int_req = !m_wait && (win >= 0) &&
                (top < 0 || mrank(win, m_lowest) < mrank(top, m_lowest));
    m_isr = (m_isr & ~clr) | setb;
    m_lowest = nlow;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    inta_1 = 0; inta_2 = 0; eoi_valid = 0; setp_valid = 0;
  endtask

  function automatic logic [24:0] dut_vec();
    return {int_req, irr_clr, ack_valid, ack_id, spurious, isr, lowest_prio};
  endfunction

  function automatic logic [24:0] mod_vec();
    return {m_int_req, m_irr_clr, m_ack_valid, W'(m_ack_id), m_spurious, m_isr, W'(m_lowest)};
  endfunction

  task automatic test_reset();
    irr = '0; imr = '0; aeoi_en = 0; rot_aeoi = 0; inta_1 = 0; inta_2 = 0;
    eoi_valid = 0; eoi_specific = 0; eoi_rotate = 0; eoi_level = '0;
    setp_valid = 0; setp_level = '0;
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== 25'({1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 3'd7})) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), mod_vec());
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic_ack();
    irr = 8'h0A; tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL basic_int_req got %b exp 1", int_req); end
    inta_1 = 1; tick();
    checks++; if (irr_clr !== 8'h02) begin errors++; $display("FAIL basic_irr_clr got %h exp 02", irr_clr); end
    checks++; if (isr !== 8'h02) begin errors++; $display("FAIL basic_isr got %h exp 02", isr); end
    irr = 8'h08; inta_2 = 1; tick();
    checks++;
    if ({ack_valid, ack_id, spurious} !== {1'b1, 3'd1, 1'b0}) begin
      errors++; $display("FAIL basic_ack got v%b id%0d s%b exp v1 id1 s0", ack_valid, ack_id, spurious);
    end
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL basic_no_preempt got %b exp 0", int_req); end
    irr = '0; eoi_valid = 1; eoi_specific = 0; tick();
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL basic_eoi got %h exp 00", isr); end
  endtask

  task automatic test_nesting();
    irr = 8'h08; tick();
    inta_1 = 1; tick();
    irr = 8'h01; inta_2 = 1; tick();
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL nest_int_req got %b exp 1", int_req); end
    inta_1 = 1; tick();
    irr = 8'h00; inta_2 = 1; tick();
    checks++; if (isr !== 8'h09) begin errors++; $display("FAIL nest_isr got %h exp 09", isr); end
    eoi_valid = 1; eoi_specific = 0; tick();
    checks++; if (isr !== 8'h08) begin errors++; $display("FAIL nest_eoi got %h exp 08", isr); end
    eoi_valid = 1; tick();
  endtask

  task automatic test_aeoi_rotation();
    aeoi_en = 1; rot_aeoi = 1; irr = 8'h24; tick();
    inta_1 = 1; tick();
    irr = 8'h20; inta_2 = 1; tick();
    checks++;
    if ({ack_id, lowest_prio, isr} !== {3'd2, 3'd2, 8'h00}) begin
      errors++; $display("FAIL aeoi_first got id%0d low%0d isr%h exp id2 low2 isr00", ack_id, lowest_prio, isr);
    end
    tick();
    inta_1 = 1; tick();
    irr = 8'h00; inta_2 = 1; tick();
    checks++;
    if ({ack_id, lowest_prio} !== {3'd5, 3'd5}) begin
      errors++; $display("FAIL aeoi_second got id%0d low%0d exp id5 low5", ack_id, lowest_prio);
    end
    aeoi_en = 0; rot_aeoi = 0; setp_valid = 1; setp_level = 3'd7; tick();
  endtask

  task automatic test_specific_rotate();
    eoi_valid = 1; eoi_specific = 1; eoi_rotate = 1; eoi_level = 3'd4; tick();
    checks++; if (lowest_prio !== 3'd4) begin errors++; $display("FAIL spec_rot got %0d exp 4", lowest_prio); end
    eoi_specific = 0; eoi_rotate = 0;
    irr = 8'h11; tick();
    inta_1 = 1; tick();
    checks++; if (irr_clr !== 8'h01) begin errors++; $display("FAIL spec_winner got %h exp 01", irr_clr); end
    irr = 8'h10; inta_2 = 1; tick();
    checks++; if (ack_id !== 3'd0) begin errors++; $display("FAIL spec_ack got %0d exp 0", ack_id); end
    irr = '0; eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd0; tick();
    eoi_specific = 0; setp_valid = 1; setp_level = 3'd7; tick();
  endtask

  task automatic test_spurious();
    irr = 8'h80; tick();
    irr = 8'h00; inta_1 = 1; tick();
    checks++;
    if ({irr_clr, isr} !== 16'h0000) begin
      errors++; $display("FAIL spur_inta1 got clr%h isr%h exp 00 00", irr_clr, isr);
    end
    inta_2 = 1; tick();
    checks++;
    if ({ack_valid, ack_id, spurious} !== {1'b1, 3'd7, 1'b1}) begin
      errors++; $display("FAIL spur_ack got v%b id%0d s%b exp v1 id7 s1", ack_valid, ack_id, spurious);
    end
    inta_2 = 1; tick();
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL idle_inta2 got %b exp 0", ack_valid); end
  endtask

  task automatic test_simultaneous();
    irr = 8'h10; tick();
    inta_1 = 1; tick();
    irr = 8'h04; inta_2 = 1; tick();
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL simul_int_req got %b exp 1", int_req); end
    inta_1 = 1; eoi_valid = 1; eoi_specific = 0; tick();
    checks++; if (isr !== 8'h04) begin errors++; $display("FAIL simul_isr got %h exp 04", isr); end
    irr = '0; inta_2 = 1; tick();
    eoi_valid = 1; tick();
  endtask

  task automatic test_reset_mid();
    irr = 8'h01; tick();
    inta_1 = 1; tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== mod_vec()) begin
      errors++; $display("FAIL reset_mid_state got %h exp %h", dut_vec(), mod_vec());
    end
    @(negedge clk);
    rst_n = 1; irr = '0; inta_2 = 1; tick();
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_ack got %b exp 0", ack_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      irr = N'($urandom & $urandom);
      imr = N'($urandom & $urandom & $urandom);
      aeoi_en = $urandom_range(0, 1) == 1;
      rot_aeoi = $urandom_range(0, 1) == 1;
      inta_1 = $urandom_range(0, 3) == 0;
      inta_2 = $urandom_range(0, 3) == 0;
      eoi_valid = $urandom_range(0, 5) == 0;
      eoi_specific = $urandom_range(0, 1) == 1;
      eoi_rotate = $urandom_range(0, 1) == 1;
      eoi_level = W'($urandom_range(0, N - 1));
      setp_valid = $urandom_range(0, 9) == 0;
      setp_level = W'($urandom_range(0, N - 1));
      tick();
      checks++;
      if (dut_vec() !== mod_vec()) begin
        errors++; $display("FAIL rand_cyc%0d got %h exp %h", c, dut_vec(), mod_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_nesting();
    test_aeoi_rotation();
    test_specific_rotate();
    test_spurious();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
